// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin owner selection for a single byte-level UART
// transmitter. One source keeps the transmitter for a whole message; bytes
// are pulled one at a time via req_ack. An idle gap follows every message.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 50000,
    parameter int TIMEOUT    = 10000
) (
    input  logic                 clk_50M,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_done,
    output logic                 busy,
    output logic                 err
);

    localparam int IW      = $clog2(NUM_REQ);
    // One counter serves both the tx_done timeout and the gap; it only has
    // to reach the larger terminal value minus one.
    localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_SEND = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;
    // With no gap configured the message end goes straight back to IDLE, so
    // the next owner is granted two clocks after the final tx_done.
    localparam logic [2:0] S_DONE = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

    logic [2:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [7:0]         data_q, data_d;
    logic               lastb_q, lastb_d;
    logic               err_q, err_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               pick_vld;
    logic [IW-1:0]      pick_idx;
    logic               sel_req;
    logic               sel_last;
    logic [7:0]         sel_data;

    // Round-robin search: first pending requester after the previous winner.
    always_comb begin
        logic [IW-1:0] cand;
        cand     = '0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(rr_q) + k) % NUM_REQ);
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Mux the granted requester's byte, last flag and request line.
    always_comb begin
        sel_req  = |(req & grant_q);
        sel_last = |(req_last & grant_q);
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) sel_data = req_data[8*i +: 8];
        end
    end

    // Message-level FSM: arbitrate, fetch byte, start, wait, gap.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        data_d  = data_q;
        lastb_d = lastb_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    grant_d = NUM_REQ'(1) << pick_idx;
                    rr_d    = pick_idx;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (sel_req) begin
                    data_d  = sel_data;
                    lastb_d = sel_last;
                    state_d = S_SEND;
                end else begin
                    // Source withdrew mid-message: drop it without sending.
                    grant_d = '0;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_SEND: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (tx_done) begin
                    if (lastb_q) begin
                        grant_d = '0;
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    grant_d = '0;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) state_d = S_IDLE;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset puts the pointer on the last requester so
    // requester 0 wins first.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            rr_q    <= IW'(NUM_REQ - 1);
            data_q  <= '0;
            lastb_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            data_q  <= data_d;
            lastb_q <= lastb_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant    = grant_q;
    assign tx_data  = data_q;
    assign err      = err_q;
    assign busy     = (state_q != S_IDLE);
    assign tx_start = (state_q == S_SEND);
    // Ack only while the owner still presents a byte in LOAD.
    assign req_ack  = (state_q == S_LOAD) ? (req & grant_q) : '0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: dut_a (gap 8, long timeout) runs message-level
// sequences with a producer/transmitter model; dut_b (no gap, timeout 16)
// runs an arbitration vector table plus timeout and back-to-back cases.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int GAP_A = 8;
    localparam int TO_A  = 256;
    localparam int TO_B  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rstA_n, rstB_n;
    logic [N-1:0]   reqA, lastA, ackA, grantA;
    logic [8*N-1:0] dataA;
    logic           startA, doneA, busyA, errA;
    logic [7:0]     txdA;
    logic [N-1:0]   reqB, lastB, ackB, grantB;
    logic [8*N-1:0] dataB;
    logic           startB, doneB, busyB, errB;
    logic [7:0]     txdB;

    uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP_A), .TIMEOUT(TO_A)) dut_a (
        .clk_50M(clk), .rst_n(rstA_n), .req(reqA), .req_data(dataA), .req_last(lastA),
        .req_ack(ackA), .grant(grantA), .tx_start(startA), .tx_data(txdA),
        .tx_done(doneA), .busy(busyA), .err(errA));

    uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(0), .TIMEOUT(TO_B)) dut_b (
        .clk_50M(clk), .rst_n(rstB_n), .req(reqB), .req_data(dataB), .req_last(lastB),
        .req_ack(ackB), .grant(grantB), .tx_start(startB), .tx_data(txdB),
        .tx_done(doneB), .busy(busyB), .err(errB));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // producer / transmitter model state for dut_a
    logic [7:0]   msg   [N][4];
    logic         lastf [N][4];
    int           len   [N];
    int           ptr   [N];
    bit           active[N];
    int           ackcnt[N];
    int           cyc, done_cnt, tx_dly, t;
    bit           wd2;
    logic [N-1:0] ack_n, prev_g;
    logic         start_n, done_n, prev_b;
    int           grise, gfall, bfall, ldone, n_badg;
    logic [N-1:0] slog_g[$];
    logic [7:0]   slog_d[$];
    int           slog_c[$];
    logic [N-1:0] glog[$];

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  gnt;
        logic [7:0]  byt;
    } vec_t;
    vec_t vt[8];
    logic [11:0] exp2[4];
    logic [11:0] exp3[3];

    task automatic drive_a();
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = (ptr[i] < len[i]) ? ptr[i] : 0;
            reqA[i]          = active[i] && (ptr[i] < len[i]);
            dataA[8*i +: 8]  = msg[i][idx];
            lastA[i]         = lastf[i][idx];
        end
    endtask

    task automatic set_msg(input int i, input int n, input logic [31:0] b, input logic [3:0] l);
        for (int k = 0; k < 4; k++) begin
            msg[i][k]   = b[8*k +: 8];
            lastf[i][k] = l[k];
        end
        len[i] = n; ptr[i] = 0; active[i] = 1'b1;
    endtask

    task automatic clear_logs();
        slog_g.delete(); slog_d.delete(); slog_c.delete(); glog.delete();
        for (int i = 0; i < N; i++) ackcnt[i] = 0;
    endtask

    // One dut_a clock: observe at negedge, update models just after posedge.
    task automatic tick_a();
        @(negedge clk);
        if (grantA != '0 && grantA != 4'b0001) n_badg++;
        if (startA) begin
            slog_g.push_back(grantA); slog_d.push_back(txdA); slog_c.push_back(cyc);
        end
        for (int i = 0; i < N; i++) if (ackA[i]) ackcnt[i]++;
        if (prev_g == '0 && grantA != '0) begin glog.push_back(grantA); grise = cyc; end
        if (prev_g != '0 && grantA == '0) gfall = cyc;
        if (prev_b && !busyA) bfall = cyc;
        if (doneA) ldone = cyc;
        prev_g = grantA; prev_b = busyA;
        ack_n = ackA; start_n = startA; done_n = doneA;
        @(posedge clk); #1;
        cyc++;
        for (int i = 0; i < N; i++) if (ack_n[i]) ptr[i]++;
        if (wd2 && done_n) active[2] = 1'b0;
        doneA = 1'b0;
        if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) doneA = 1'b1;
        end
        if (start_n) done_cnt = tx_dly - 1;
        drive_a();
    endtask

    task automatic wait_idle_a(input string name, input int lim);
        int k;
        k = 0;
        while ((busyA || reqA != '0) && k < lim) begin
            tick_a();
            k++;
        end
        chk(name, 32'(k < lim), 32'd1);
        tick_a();
    endtask

    task automatic reset_a();
        #1 rstA_n = 1'b0;
        for (int i = 0; i < N; i++) active[i] = 1'b0;
        done_cnt = 0; doneA = 1'b0;
        drive_a();
        tick_a(); tick_a();
        rstA_n = 1'b1;
        clear_logs();
    endtask

    task automatic tick_b();
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rstA_n = 1'b0; rstB_n = 1'b0;
        doneA = 1'b0; doneB = 1'b0;
        reqB = '0; lastB = '0; dataB = '0;
        for (int i = 0; i < N; i++) begin
            len[i] = 0; ptr[i] = 0; active[i] = 1'b0; ackcnt[i] = 0;
            for (int k = 0; k < 4; k++) begin msg[i][k] = 8'h00; lastf[i][k] = 1'b0; end
        end
        cyc = 0; done_cnt = 0; tx_dly = 100; wd2 = 1'b0; t = 0;
        prev_g = '0; prev_b = 1'b0; ack_n = '0; start_n = 1'b0; done_n = 1'b0;
        grise = -1; gfall = -1; bfall = -1; ldone = -1; n_badg = 0;
        drive_a();

        vt[0] = '{4'b0110, 32'h44332211, 4'b0010, 8'h22};
        vt[1] = '{4'b0110, 32'h88776655, 4'b0100, 8'h77};
        vt[2] = '{4'b1011, 32'hCCBBAA99, 4'b1000, 8'hCC};
        vt[3] = '{4'b1011, 32'h1F2E3D4C, 4'b0001, 8'h4C};
        vt[4] = '{4'b0001, 32'h000000A5, 4'b0001, 8'hA5};
        vt[5] = '{4'b1111, 32'hF0E1D2C3, 4'b0010, 8'hD2};
        vt[6] = '{4'b1001, 32'h5A6B7C8D, 4'b1000, 8'h5A};
        vt[7] = '{4'b0100, 32'h01020304, 4'b0100, 8'h02};
        exp2 = '{12'h211, 12'h212, 12'h831, 12'h832};
        exp3 = '{12'h213, 12'h421, 12'h214};

        #2;
        chk("reset_a_outputs", 32'({grantA, ackA, startA, txdA, busyA, errA}), 32'd0);
        chk("reset_b_outputs", 32'({grantB, ackB, startB, txdB, busyB, errB}), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstA_n = 1'b1; rstB_n = 1'b1;

        // single message "Hi\n" on requester 0, 100-clock transmitter
        clear_logs(); n_badg = 0; tx_dly = 100;
        set_msg(0, 3, 32'h000A6948, 4'b0100); drive_a(); t = cyc;
        wait_idle_a("t1_idle", 2000);
        chk("t1_grant_lat", 32'(grise - t), 32'd1);
        chk("t1_start_lat", 32'(slog_c[0] - t), 32'd2);
        chk("t1_nstart", 32'(slog_d.size()), 32'd3);
        chk("t1_byte0", 32'({slog_g[0], slog_d[0]}), 32'h148);
        chk("t1_byte1", 32'({slog_g[1], slog_d[1]}), 32'h169);
        chk("t1_byte2", 32'({slog_g[2], slog_d[2]}), 32'h10A);
        chk("t1_acks", 32'(ackcnt[0]), 32'd3);
        chk("t1_grant_only0", 32'(n_badg), 32'd0);
        chk("t1_grant_drop", 32'(gfall - ldone), 32'd1);
        chk("t1_busy_drop", 32'(bfall - ldone), 32'(GAP_A + 1));

        // contention from reset, then fairness against a continuous holder
        reset_a(); tx_dly = 20;
        set_msg(1, 2, 32'h00001211, 4'b0010);
        set_msg(3, 2, 32'h00003231, 4'b0010);
        drive_a();
        wait_idle_a("t2_idle", 2000);
        chk("t2_nstart", 32'(slog_d.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("t2_byte%0d", k), 32'({slog_g[k], slog_d[k]}), 32'(exp2[k]));
        clear_logs();
        set_msg(1, 2, 32'h00001413, 4'b0011);
        set_msg(2, 1, 32'h00000021, 4'b0001);
        drive_a();
        wait_idle_a("t2b_idle", 2000);
        chk("t2b_nstart", 32'(slog_d.size()), 32'd3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("t2b_byte%0d", k), 32'({slog_g[k], slog_d[k]}), 32'(exp3[k]));

        // withdrawal of requester 2 after its first byte completes
        clear_logs(); wd2 = 1'b1;
        set_msg(2, 2, 32'h00002B2A, 4'b0010); drive_a();
        wait_idle_a("t3_idle", 2000);
        wd2 = 1'b0;
        chk("t3_nstart", 32'(slog_d.size()), 32'd1);
        chk("t3_byte0", 32'({slog_g[0], slog_d[0]}), 32'h42A);
        chk("t3_acks", 32'(ackcnt[2]), 32'd1);
        chk("t3_grant_drop", 32'(gfall - ldone), 32'd2);
        chk("t3_busy_drop", 32'(bfall - ldone), 32'(GAP_A + 2));
        chk("t3_err", 32'(errA), 32'd0);

        // asynchronous reset during WAIT of byte 2
        clear_logs();
        set_msg(0, 3, 32'h00030201, 4'b0100);
        set_msg(1, 1, 32'h00000071, 4'b0001);
        drive_a();
        begin
            int k;
            k = 0;
            while (slog_d.size() < 2 && k < 500) begin tick_a(); k++; end
            chk("t4_second_start", 32'(k < 500), 32'd1);
        end
        tick_a(); tick_a(); tick_a();
        #1 rstA_n = 1'b0;
        #1;
        chk("t4_rst_grant", 32'(grantA), 32'd0);
        chk("t4_rst_ack", 32'(ackA), 32'd0);
        chk("t4_rst_start", 32'(startA), 32'd0);
        chk("t4_rst_data", 32'(txdA), 32'd0);
        chk("t4_rst_busy", 32'(busyA), 32'd0);
        chk("t4_rst_err", 32'(errA), 32'd0);
        done_cnt = 0; doneA = 1'b0;
        tick_a(); tick_a();
        clear_logs();
        rstA_n = 1'b1;
        wait_idle_a("t4_idle", 2000);
        chk("t4_first_grant", 32'(glog[0]), 32'h1);
        chk("t4_resume0", 32'({slog_g[0], slog_d[0]}), 32'h103);
        chk("t4_resume1", 32'({slog_g[1], slog_d[1]}), 32'h271);

        // arbitration vector table on dut_b (no gap)
        for (int i = 0; i < 8; i++) begin
            reqB = vt[i].req; dataB = vt[i].data; lastB = 4'hF;
            tick_b();
            chk($sformatf("v%0d_grant", i), 32'(grantB), 32'(vt[i].gnt));
            chk($sformatf("v%0d_ack", i), 32'(ackB), 32'(vt[i].gnt));
            tick_b();
            reqB = '0;
            chk($sformatf("v%0d_start", i), 32'({startB, txdB}), 32'({1'b1, vt[i].byt}));
            tick_b();
            doneB = 1'b1;
            tick_b();
            doneB = 1'b0;
            chk($sformatf("v%0d_idle", i), 32'({grantB, busyB}), 32'd0);
        end

        // timeout: tx_done never arrives
        reqB = 4'b0001; dataB = 32'h00000055; lastB = 4'hF;
        tick_b();
        tick_b();
        reqB = '0;
        chk("to_start", 32'({startB, txdB}), 32'h155);
        tick_b();
        for (int k = 0; k < TO_B - 1; k++) tick_b();
        chk("to_before", 32'({errB, grantB}), 32'h01);
        tick_b();
        chk("to_err", 32'({errB, grantB, busyB}), 32'h20);

        // back-to-back with no gap: second grant two clocks after tx_done
        reqB = 4'b0011; dataB = 32'h00006261;
        tick_b();
        chk("g0_grant1", 32'(grantB), 32'h2);
        tick_b();
        reqB = 4'b0001;
        chk("g0_data1", 32'({startB, txdB}), 32'h162);
        tick_b();
        doneB = 1'b1;
        tick_b();
        doneB = 1'b0;
        chk("g0_drop", 32'(grantB), 32'd0);
        tick_b();
        chk("g0_grant2", 32'({grantB, ackB}), 32'h11);
        tick_b();
        reqB = '0;
        chk("g0_data2", 32'({startB, txdB}), 32'h161);
        tick_b();
        doneB = 1'b1;
        tick_b();
        doneB = 1'b0;
        chk("g0_err_sticky", 32'({errB, busyB}), 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one byte-level UART transmitter among `NUM_REQ` message sources (status text, sensor reports, debug strings). Each source streams bytes through a per-byte ack handshake. The arbiter grants one source for a whole message and issues start pulses to the transmitter one byte at a time. It then inserts an idle gap before re-arbitrating. It sits between the message producers and the UART Tx core, in place of the free-running start counter used so far.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..8).
- `GAP_CYCLES`, default 50000: idle clocks after each message (1 ms at 50 MHz); 0 = no gap.
- `TIMEOUT`, default 10000: max clocks waiting for `tx_done` before abort (> one 115200-baud frame = 4340 clocks).
- `clk_50M` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in NUM_REQ: requester i has a message byte pending; held high until its last byte is acked.
- `req_data` in 8*NUM_REQ: current byte of requester i at bits [8i+7:8i].
- `req_last` in NUM_REQ: current byte of requester i is the final byte of its message.
- `req_ack` out NUM_REQ: one-cycle pulse; the byte of requester i was taken, and the requester advances to its next byte.
- `grant` out NUM_REQ: one-hot owner of the transmitter; 0 when idle.
- `tx_start` out 1: one-cycle start pulse to the UART byte transmitter.
- `tx_data` out 8: byte to transmit; stable from `tx_start` until `tx_done`.
- `tx_done` in 1: one-cycle pulse from the transmitter after the stop bit.
- `busy` out 1: high in every state except IDLE.
- `err` out 1: sticky; set on timeout; cleared only by reset.

## Operation
- Reset values:
  - state IDLE.
  - `grant`, `req_ack`, `tx_start`, `tx_data`, `busy`, `err` all 0.
  - round-robin pointer `last` = NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, LOAD, SEND, WAIT, GAP.
- IDLE:
  - If `req` != 0, pick the first set bit searching from `last`+1 upward, with wrap-around.
  - Register it into `grant`, update `last` to the winner, and go to LOAD.
- LOAD:
  - If `req[g]` = 1: latch `req_data[g]` into `tx_data` and `req_last[g]` into `last_q`, pulse `req_ack[g]`, and go to SEND.
  - If `req[g]` = 0 (source withdrew mid-message): clear `grant` and go to GAP, without sending a byte.
- SEND: pulse `tx_start`, clear the timeout counter, and go to WAIT.
- WAIT:
  - On `tx_done`: if `last_q`, clear `grant` and go to GAP; otherwise go to LOAD.
  - If the counter reaches TIMEOUT-1 without `tx_done`: set `err`, clear `grant`, and go to GAP.
- GAP:
  - Count GAP_CYCLES clocks, then go to IDLE.
  - If GAP_CYCLES = 0, go to IDLE on the next clock.
- `tx_done` outside WAIT is ignored.
- `req` changes on non-granted lines never affect the current message.
- Counter widths are sized with `$clog2` of the parameter; counters never wrap within a state.

## Timing
- Request seen in IDLE at cycle t:
  - `grant` high at t+1 (LOAD), with `req_ack` pulsing in the same cycle.
  - `tx_start` and valid `tx_data` at t+2.
  - WAIT from t+3.
- Between bytes: `tx_done` at cycle u gives LOAD at u+1 (ack) and `tx_start` at u+2. Byte-to-byte overhead is 2 clocks.
- After the last byte: `grant` drops at u+1, and arbitration resumes at u+1+GAP_CYCLES+1.
- `req_ack` and `tx_start` are never high for more than one cycle. At most one bit of `req_ack` is high at a time.
- Simultaneous requests are served in round-robin order. A requester holding `req` continuously cannot be granted twice in a row while another requester is pending.
- Reset asserted mid-message: all outputs go to 0 immediately (asynchronously). The partial message is abandoned, and `last` returns to NUM_REQ-1.

## Test plan
- Single message: `req[0]` with 3 bytes "Hi\n" (`req_last` on 0x0A); transmitter model returns `tx_done` 100 clocks after each start.
  - Required: three `tx_start` pulses with `tx_data` 0x48, 0x69, 0x0A; three `req_ack[0]` pulses.
  - Required: `grant` = 0001 throughout, then 0 for GAP_CYCLES, then `busy` = 0.
- Contention: `req[1]` and `req[3]` rise in the same cycle from reset, each with a 2-byte message.
  - Required: requester 1 served fully first, then requester 3; no interleaved bytes.
  - Then `req[1]` re-asserts while `req[2]` is pending: requester 2 is granted before requester 1.
- Withdrawal: `req[2]` drops after its first byte's `tx_done`.
  - Required: no second `tx_start`; `grant` cleared in LOAD; GAP then IDLE; `err` stays 0.
- Timeout: with TIMEOUT=16 and `tx_done` never asserted.
  - Required: `err` = 1 exactly 16 clocks after WAIT entry; `grant` = 0; the next request is still served normally.
- Reset mid-transfer: assert `rst_n` = 0 during WAIT of byte 2.
  - Required: all outputs 0 without a clock edge; after release, requester 0 has priority and the message restarts from the producer's current byte.
- Gap disabled: GAP_CYCLES=0 with two back-to-back requesters.
  - Required: the second `grant` is asserted 2 clocks after the first message's final `tx_done`.
